ps2_digit_decoder: RTL and testbench

//   Receives PS/2 keyboard frames (scan code set 2) and decodes digit keys 0-9 to 4-bit values.

---
 rtl/ps2_digit_decoder.sv | 201 ++++++++++++++++++++
 tb/tb_ps2_digit_decoder.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_digit_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_digit_decoder
//  Purpose  : Receives PS/2 keyboard frames (scan code set 2), decodes the
//             make codes of digit keys 0-9 into a 4-bit value and the Enter
//             key into an operation pulse. Break (release) sequences are
//             filtered. Feeds the BCD digit shift register downstream.
//  Ports    : clk             - system clock, rising edge
//             rst             - synchronous active-high reset
//             kb_clk          - PS/2 clock (asynchronous, idles high)
//             kb_data         - PS/2 data  (asynchronous, idles high)
//             binary_val      - last decoded digit value 0-9 (held)
//             valid_scan_code - 1-cycle pulse, new digit on binary_val
//             op_ctrl         - 1-cycle pulse, Enter pressed
//             parity_err      - 1-cycle pulse, frame dropped (parity/stop)
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_digit_decoder #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       kb_clk,
    input  logic       kb_data,
    output logic [3:0] binary_val,
    output logic       valid_scan_code,
    output logic       op_ctrl,
    output logic       parity_err
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_to_w = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] c_code_ext   = 8'hE0;
    localparam logic [7:0] c_code_brk   = 8'hF0;
    localparam logic [7:0] c_code_enter = 8'h5A;

    // Bit counter positions inside a frame (start bit already consumed)
    localparam logic [3:0] c_bit_parity = 4'd8;

    // ------------------------------------------------------------------------
    // Input synchronisers. Reset to 1 so the idle-high lines do not produce
    // a spurious falling edge when reset is released.
    // ------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_kbc_sync;
    logic [SYNC_STAGES-1:0] r_kbd_sync;
    logic                   r_kbc_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_kbc_sync <= '1;
            r_kbd_sync <= '1;
            r_kbc_prev <= 1'b1;
        end else begin
            r_kbc_sync <= {r_kbc_sync[SYNC_STAGES-2:0], kb_clk};
            r_kbd_sync <= {r_kbd_sync[SYNC_STAGES-2:0], kb_data};
            r_kbc_prev <= r_kbc_sync[SYNC_STAGES-1];
        end
    end

    logic w_kbc;
    logic w_kbd;
    logic w_fall;

    assign w_kbc  = r_kbc_sync[SYNC_STAGES-1];
    assign w_kbd  = r_kbd_sync[SYNC_STAGES-1];
    assign w_fall = r_kbc_prev & ~w_kbc;

    // ------------------------------------------------------------------------
    // Frame state and datapath registers
    // ------------------------------------------------------------------------
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RECV = 1'b1
    } state_t;

    state_t            r_state;
    logic [3:0]        r_bit_cnt;   // edges seen after the start bit
    logic [7:0]        r_data;      // data byte, shifted in LSB first
    logic              r_par;       // received parity bit
    logic [c_to_w-1:0] r_to_cnt;    // cycles since last falling edge in RECV
    logic              r_ext;       // E0 prefix seen
    logic              r_brk;       // F0 prefix seen

    // ------------------------------------------------------------------------
    // Digit make-code lookup on the assembled byte
    // ------------------------------------------------------------------------
    logic       w_digit_hit;
    logic [3:0] w_digit_val;

    always_comb begin
        w_digit_hit = 1'b1;
        w_digit_val = 4'd0;
        case (r_data)
            8'h45:   w_digit_val = 4'd0;
            8'h16:   w_digit_val = 4'd1;
            8'h1E:   w_digit_val = 4'd2;
            8'h26:   w_digit_val = 4'd3;
            8'h25:   w_digit_val = 4'd4;
            8'h2E:   w_digit_val = 4'd5;
            8'h36:   w_digit_val = 4'd6;
            8'h3D:   w_digit_val = 4'd7;
            8'h3E:   w_digit_val = 4'd8;
            8'h46:   w_digit_val = 4'd9;
            default: w_digit_hit = 1'b0;
        endcase
    end

    // Odd parity: the data bits plus parity bit must contain an odd number
    // of ones. The stop bit is the current sampled data value.
    logic w_frame_ok;
    assign w_frame_ok = (^{r_data, r_par}) & w_kbd;

    // ------------------------------------------------------------------------
    // Frame FSM, prefix tracking and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_bit_cnt       <= 4'd0;
            r_data          <= 8'd0;
            r_par           <= 1'b0;
            r_to_cnt        <= '0;
            r_ext           <= 1'b0;
            r_brk           <= 1'b0;
            binary_val      <= 4'd0;
            valid_scan_code <= 1'b0;
            op_ctrl         <= 1'b0;
            parity_err      <= 1'b0;
        end else begin
            // Pulses default low so every assertion lasts a single cycle
            valid_scan_code <= 1'b0;
            op_ctrl         <= 1'b0;
            parity_err      <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_bit_cnt <= 4'd0;
                    r_to_cnt  <= '0;
                    // A falling edge with data high is not a start bit
                    if (w_fall && !w_kbd) begin
                        r_state <= S_RECV;
                    end
                end

                S_RECV: begin
                    if (w_fall) begin
                        r_to_cnt  <= '0;
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (r_bit_cnt < c_bit_parity) begin
                            r_data <= {w_kbd, r_data[7:1]};
                        end else if (r_bit_cnt == c_bit_parity) begin
                            r_par <= w_kbd;
                        end else begin
                            // Stop-bit edge: frame complete
                            r_state   <= S_IDLE;
                            r_bit_cnt <= 4'd0;
                            if (!w_frame_ok) begin
                                parity_err <= 1'b1;
                            end else if (r_data == c_code_ext) begin
                                r_ext <= 1'b1;
                            end else if (r_data == c_code_brk) begin
                                r_brk <= 1'b1;
                            end else begin
                                // Any other byte terminates a prefix
                                // sequence; a pending break swallows it.
                                r_ext <= 1'b0;
                                r_brk <= 1'b0;
                                if (!r_brk) begin
                                    if (r_data == c_code_enter) begin
                                        op_ctrl <= 1'b1;
                                    end else if (w_digit_hit && !r_ext) begin
                                        binary_val      <= w_digit_val;
                                        valid_scan_code <= 1'b1;
                                    end
                                end
                            end
                        end
                    end else if (r_to_cnt == c_to_last) begin
                        // Keyboard stalled mid-frame: drop it silently
                        r_state   <= S_IDLE;
                        r_bit_cnt <= 4'd0;
                        r_to_cnt  <= '0;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_digit_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_digit_decoder
//  Purpose  : Self-checking bench for ps2_digit_decoder. Drives PS/2 frames
//             and compares observed pulses and binary_val against a
//             byte-level reference model of the scan-code rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_digit_decoder;

    localparam int TO_CYCLES = 300;
    localparam int HALF_BIT  = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic       kb_clk;
    logic       kb_data;
    logic [3:0] binary_val;
    logic       valid_scan_code;
    logic       op_ctrl;
    logic       parity_err;

    ps2_digit_decoder #(
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (TO_CYCLES)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .kb_clk          (kb_clk),
        .kb_data         (kb_data),
        .binary_val      (binary_val),
        .valid_scan_code (valid_scan_code),
        .op_ctrl         (op_ctrl),
        .parity_err      (parity_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // ------------------------------------------------------------------------
    // Pulse monitor: counts pulses and flags overlap or over-long pulses
    // ------------------------------------------------------------------------
    int   n_valid = 0;
    int   n_op    = 0;
    int   n_perr  = 0;
    int   viol    = 0;
    logic p_valid = 1'b0;
    logic p_op    = 1'b0;
    logic p_perr  = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            p_valid <= 1'b0;
            p_op    <= 1'b0;
            p_perr  <= 1'b0;
        end else begin
            if (valid_scan_code) n_valid <= n_valid + 1;
            if (op_ctrl)         n_op    <= n_op + 1;
            if (parity_err)      n_perr  <= n_perr + 1;
            if ((int'(valid_scan_code) + int'(op_ctrl) + int'(parity_err)) > 1) begin
                viol <= viol + 1;
                $display("FAIL exclusive_pulses: valid=%0b op=%0b perr=%0b, required at most one high",
                         valid_scan_code, op_ctrl, parity_err);
            end
            if ((valid_scan_code && p_valid) || (op_ctrl && p_op) || (parity_err && p_perr)) begin
                viol <= viol + 1;
                $display("FAIL pulse_width: pulse held for 2+ cycles, required exactly 1");
            end
            p_valid <= valid_scan_code;
            p_op    <= op_ctrl;
            p_perr  <= parity_err;
        end
    end

    // ------------------------------------------------------------------------
    // Reference model: byte-level scan-code rules
    // ------------------------------------------------------------------------
    int         exp_valid = 0;
    int         exp_op    = 0;
    int         exp_perr  = 0;
    logic [3:0] exp_val   = 4'd0;
    bit         m_ext     = 1'b0;
    bit         m_brk     = 1'b0;

    logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                     8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

    function automatic void model_byte(input logic [7:0] b);
        int idx;
        idx = -1;
        for (int i = 0; i < 10; i++) if (digit_codes[i] == b) idx = i;
        if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            if (!m_brk) begin
                if (b == 8'h5A) begin
                    exp_op++;
                end else if (idx >= 0 && !m_ext) begin
                    exp_val = idx[3:0];
                    exp_valid++;
                end
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endfunction

    // ------------------------------------------------------------------------
    // Stimulus helpers (inputs change on the falling clk edge)
    // ------------------------------------------------------------------------
    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ps2_bit(input logic b);
        kb_data = b;
        wait_clks(HALF_BIT);
        kb_clk = 1'b0;
        wait_clks(HALF_BIT);
        kb_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic par;
        par = ~(^b) ^ bad_par;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        ps2_bit(~bad_stop);
        kb_data = 1'b1;
        wait_clks(HALF_BIT);
        if (bad_par || bad_stop) exp_perr++;
        else model_byte(b);
    endtask

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    task automatic test_reset();
        kb_clk  = 1'b1;
        kb_data = 1'b1;
        rst     = 1'b1;
        wait_clks(5);
        checks++;
        if ({binary_val, valid_scan_code, op_ctrl, parity_err} !== 7'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, required 0000000",
                     {binary_val, valid_scan_code, op_ctrl, parity_err});
        end
        rst = 1'b0;
        wait_clks(1000);
        checks++;
        if ((n_valid + n_op + n_perr) !== 0) begin
            errors++;
            $display("FAIL idle_no_pulses: got %0d pulses, required 0", n_valid + n_op + n_perr);
        end
        checks++;
        if (binary_val !== 4'd0) begin
            errors++;
            $display("FAIL idle_value: got %0d, required 0", binary_val);
        end
    endtask

    task automatic test_digit();
        send_frame(8'h16, 1'b0, 1'b0);
        checks++;
        if (n_valid !== 1 || binary_val !== 4'd1) begin
            errors++;
            $display("FAIL digit_1: got pulses=%0d val=%0d, required pulses=1 val=1", n_valid, binary_val);
        end
        wait_clks(200);
        checks++;
        if (binary_val !== 4'd1 || n_valid !== 1) begin
            errors++;
            $display("FAIL digit_hold: got val=%0d pulses=%0d, required val=1 pulses=1", binary_val, n_valid);
        end
    endtask

    task automatic test_release();
        send_frame(8'h3D, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h3D, 1'b0, 1'b0);
        checks++;
        if (n_valid !== exp_valid || binary_val !== 4'd7) begin
            errors++;
            $display("FAIL release_filter: got pulses=%0d val=%0d, required pulses=%0d val=7",
                     n_valid, binary_val, exp_valid);
        end
    endtask

    task automatic test_enter();
        int v0;
        v0 = n_valid;
        send_frame(8'h5A, 1'b0, 1'b0);
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b0);
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b0);
        checks++;
        if (n_op !== 2 || exp_op !== 2) begin
            errors++;
            $display("FAIL enter_count: got op=%0d (model %0d), required 2", n_op, exp_op);
        end
        checks++;
        if (n_valid !== v0) begin
            errors++;
            $display("FAIL enter_no_digit: got valid=%0d, required %0d", n_valid, v0);
        end
        // Extended digit code must be ignored
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h46, 1'b0, 1'b0);
        checks++;
        if (n_valid !== v0 || binary_val !== exp_val) begin
            errors++;
            $display("FAIL ext_digit_ignored: got valid=%0d val=%0d, required valid=%0d val=%0d",
                     n_valid, binary_val, v0, exp_val);
        end
    endtask

    task automatic test_errors();
        int v0;
        v0 = n_valid;
        send_frame(8'h45, 1'b1, 1'b0);
        checks++;
        if (n_perr !== 1 || n_valid !== v0 || binary_val !== exp_val) begin
            errors++;
            $display("FAIL bad_parity: got perr=%0d valid=%0d val=%0d, required perr=1 valid=%0d val=%0d",
                     n_perr, n_valid, binary_val, v0, exp_val);
        end
        send_frame(8'h2E, 1'b0, 1'b1);
        checks++;
        if (n_perr !== 2 || n_valid !== v0) begin
            errors++;
            $display("FAIL bad_stop: got perr=%0d valid=%0d, required perr=2 valid=%0d", n_perr, n_valid, v0);
        end
    endtask

    task automatic test_start_glitch();
        ps2_bit(1'b1);      // edge with data high: not a start bit
        kb_data = 1'b1;
        wait_clks(HALF_BIT);
        send_frame(8'h25, 1'b0, 1'b0);
        checks++;
        if (binary_val !== 4'd4 || n_valid !== exp_valid || n_perr !== exp_perr) begin
            errors++;
            $display("FAIL start_high_ignored: got val=%0d valid=%0d perr=%0d, required val=4 valid=%0d perr=%0d",
                     binary_val, n_valid, n_perr, exp_valid, exp_perr);
        end
    endtask

    task automatic test_timeout();
        int tot;
        tot = n_valid + n_op + n_perr;
        ps2_bit(1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        kb_data = 1'b1;
        wait_clks(TO_CYCLES + 10);
        checks++;
        if ((n_valid + n_op + n_perr) !== tot) begin
            errors++;
            $display("FAIL timeout_silent: got %0d pulses, required %0d", n_valid + n_op + n_perr, tot);
        end
        send_frame(8'h26, 1'b0, 1'b0);
        checks++;
        if (binary_val !== 4'd3 || n_valid !== exp_valid) begin
            errors++;
            $display("FAIL after_timeout: got val=%0d valid=%0d, required val=3 valid=%0d",
                     binary_val, n_valid, exp_valid);
        end
    endtask

    task automatic test_reset_midframe();
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        rst = 1'b1;
        wait_clks(3);
        rst = 1'b0;
        exp_val = 4'd0;
        m_ext   = 1'b0;
        m_brk   = 1'b0;
        kb_data = 1'b1;
        wait_clks(10);
        checks++;
        if (binary_val !== 4'd0) begin
            errors++;
            $display("FAIL reset_clears_val: got %0d, required 0", binary_val);
        end
        send_frame(8'h1E, 1'b0, 1'b0);
        checks++;
        if (binary_val !== 4'd2 || n_valid !== exp_valid) begin
            errors++;
            $display("FAIL after_reset_frame: got val=%0d valid=%0d, required val=2 valid=%0d",
                     binary_val, n_valid, exp_valid);
        end
    endtask

    task automatic test_back_to_back();
        int v0;
        v0 = n_valid;
        for (int i = 0; i < 3; i++) send_frame(8'h36, 1'b0, 1'b0);
        checks++;
        if (n_valid !== v0 + 3 || binary_val !== 4'd6) begin
            errors++;
            $display("FAIL typematic: got valid=%0d val=%0d, required valid=%0d val=6",
                     n_valid, binary_val, v0 + 3);
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        bit         bp, bs;
        int         r;
        for (int n = 0; n < 40; n++) begin
            bp = 1'b0;
            bs = 1'b0;
            r  = $urandom_range(0, 9);
            if (r < 5)       b = digit_codes[$urandom_range(0, 9)];
            else if (r == 5) b = 8'hE0;
            else if (r == 6) b = 8'hF0;
            else if (r == 7) b = 8'h5A;
            else             b = 8'($urandom);
            if (r == 9) begin
                if ($urandom_range(0, 1) == 0) bp = 1'b1;
                else                           bs = 1'b1;
            end
            send_frame(b, bp, bs);
            checks++;
            if (n_valid !== exp_valid || n_op !== exp_op || n_perr !== exp_perr || binary_val !== exp_val) begin
                errors++;
                $display("FAIL random_%0d byte=%h: got valid=%0d op=%0d perr=%0d val=%0d, required valid=%0d op=%0d perr=%0d val=%0d",
                         n, b, n_valid, n_op, n_perr, binary_val, exp_valid, exp_op, exp_perr, exp_val);
            end
        end
    endtask

    task automatic test_protocol();
        checks++;
        if (viol !== 0) begin
            errors++;
            $display("FAIL pulse_protocol: got %0d violations, required 0", viol);
        end
    endtask

    initial begin
        test_reset();
        test_digit();
        test_release();
        test_enter();
        test_errors();
        test_start_glitch();
        test_timeout();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        wait_clks(5);
        test_protocol();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
